// File: rtl/life_cell_serial.sv
// One Game-of-Life cell (B3/S23) that sums its captured neighbour vector serially, LSB first,
// through a ripple chain of full adders. Optional macro LIFE_EARLY_DONE_EN stops counting at 4.
`timescale 1ns/1ps

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module life_cell_serial #(
  parameter int N_NEIGHBORS = 8,
  parameter bit INIT_ALIVE  = 1'b0,
  localparam int CW = $clog2(N_NEIGHBORS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_NEIGHBORS-1:0] neighbors,
  input  logic                   load,
  input  logic                   load_value,
  output logic                   alive,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  localparam logic [CW-1:0] IDX_LAST = CW'(N_NEIGHBORS - 1);

  state_t                 state_q, state_d;
  logic [N_NEIGHBORS-1:0] shreg_q;
  logic [CW-1:0]          idx_q;
  logic [CW-1:0]          count_q;
  logic                   alive_q;
  logic                   done_q;

  // Ripple adder: count_q + shreg_q[0]; the sum never exceeds N so the top carry is dropped.
  logic [CW-1:0] addend;
  logic [CW-1:0] carry;
  logic [CW-1:0] sum;
  logic          adder_cout_unused;

  assign addend   = {{(CW-1){1'b0}}, shreg_q[0]};
  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_fa
      if (gi == CW - 1) begin : g_msb
        full_adder u_fa (
          .a_i   (count_q[gi]),
          .b_i   (addend[gi]),
          .cin_i (carry[gi]),
          .sum_o (sum[gi]),
          .cout_o(adder_cout_unused)
        );
      end else begin : g_mid
        full_adder u_fa (
          .a_i   (count_q[gi]),
          .b_i   (addend[gi]),
          .cin_i (carry[gi]),
          .sum_o (sum[gi]),
          .cout_o(carry[gi+1])
        );
      end
    end
  endgenerate

  logic accum_last;
`ifdef LIFE_EARLY_DONE_EN
  // Four live neighbours already means death, so the remaining bits cannot matter.
  assign accum_last = (idx_q == IDX_LAST) || (sum == CW'(4));
`else
  assign accum_last = (idx_q == IDX_LAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_ACCUM;
      S_ACCUM:  if (accum_last) state_d = S_DECIDE;
      S_DECIDE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (load) state_d = S_IDLE;
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      alive_q <= INIT_ALIVE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        alive_q <= load_value;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              shreg_q <= neighbors;
              idx_q   <= '0;
              count_q <= '0;
            end
          end
          S_ACCUM: begin
            count_q <= sum;
            shreg_q <= shreg_q >> 1;
            idx_q   <= idx_q + CW'(1);
          end
          S_DECIDE: begin
            alive_q <= (count_q == CW'(3)) | (alive_q & (count_q == CW'(2)));
            done_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign alive = alive_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_life_cell_serial.sv
// Scoreboard bench for life_cell_serial: stimulus pushes expected (count, alive, done cycle),
// a monitor pops on every done pulse. Reference model is popcount plus the B3/S23 rule.
`timescale 1ns/1ps

module tb_life_cell_serial;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  neighbors = '0;
  logic          load = 1'b0;
  logic          load_value = 1'b0;
  logic          alive, busy, done;
  logic [CW-1:0] count;

  life_cell_serial #(.N_NEIGHBORS(N), .INIT_ALIVE(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .neighbors(neighbors),
    .load(load), .load_value(load_value),
    .alive(alive), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cnt;
    logic alv;
    int   at;
  } exp_t;
  exp_t sb[$];

  int   total = 0;
  int   bad = 0;
  logic model_alive = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding step.
  logic prev_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("done_not_consecutive", int'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("count", int'(count), e.cnt);
          chk("alive", int'(alive), int'(e.alv));
          chk("done_cycle", cyc, e.at);
          chk("busy_low_at_done", int'(busy), 0);
          $display("step done: cycle=%0d count=%0d alive=%0d", cyc, count, alive);
        end
      end
      prev_done = done;
    end
  end

  // Called at a negedge; waits for idle while scrambling inputs and poking start (ignored when busy).
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      start     = ($urandom_range(0, 3) == 0);
      neighbors = N'($urandom);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic load_cell(input logic v);
    wait_idle();
    load = 1'b1; load_value = v;
    @(negedge clk);
    load = 1'b0;
    model_alive = v;
  endtask

  task automatic step(input logic [N-1:0] nb);
    exp_t e;
    int c = 0;
    int lat = N + 2;
    wait_idle();
    for (int i = 0; i < N; i++) begin
      if (nb[i]) begin
        c++;
`ifdef LIFE_EARLY_DONE_EN
        if (c == 4) begin
          lat = i + 3;
          break;
        end
`endif
      end
    end
    e.cnt = c;
    e.alv = (c == 3) || (model_alive && c == 2);
    e.at  = cyc + lat;
    sb.push_back(e);
    model_alive = e.alv;
    start = 1'b1; neighbors = nb;
    @(negedge clk);
    start = 1'b0; neighbors = N'($urandom);
  endtask

  initial begin
    logic [N-1:0] nb;
    int partial;
    int n;

    // Reset
    @(negedge clk); @(negedge clk);
    chk("rst_alive", int'(alive), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("no_x_after_reset", int'($isunknown({alive, busy, done, count})), 0);

    // Birth, survival, death by overcrowding
    step(8'b0000_0111);
    chk("busy_after_accept", int'(busy), 1);
    load_cell(1'b1);
    step(8'b1000_0001);
    step(8'b1111_0000);

    // Start while busy is ignored: only the first vector counts, one done.
    wait_idle();
    step(8'b0000_0011);
    @(negedge clk);
    start = 1'b1; neighbors = 8'hFF;
    @(negedge clk);
    start = 1'b0;

    // Load at T+4 aborts the step: no done, partial count kept.
    wait_idle();
    nb = N'($urandom);
    start = 1'b1; neighbors = nb;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    load = 1'b1; load_value = 1'b0;
    @(negedge clk);
    load = 1'b0;
    model_alive = 1'b0;
    partial = 0;
    for (int i = 0; i < 3; i++) partial += int'(nb[i]);
    chk("load_abort_busy", int'(busy), 0);
    chk("load_abort_alive", int'(alive), 0);
    chk("load_abort_count", int'(count), partial);

    // Same-cycle load and start: load wins, no step.
    start = 1'b1; load = 1'b1; load_value = 1'b1; neighbors = 8'h07;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    model_alive = 1'b1;
    chk("load_start_busy", int'(busy), 0);
    chk("load_start_alive", int'(alive), 1);

    // Reset at T+5 of a step
    start = 1'b1; neighbors = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_alive = 1'b0;
    chk("midrst_alive", int'(alive), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_count", int'(count), 0);
    repeat (12) @(negedge clk);

    // Full sweep with both starting states
    for (int a = 0; a < 2; a++) begin
      for (int v = 0; v < 256; v++) begin
        load_cell(a[0]);
        step(N'(v));
      end
    end

    // Random back-to-back evolution with occasional loads
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 7) == 0) load_cell(1'($urandom));
      step(N'($urandom));
    end

    // Drain scoreboard with a bound
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", sb.size(), 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
